led_pwm_drive: RTL and testbench
================================

# led_pwm_drive

Parametrised multi-channel LED driver; next generation of the fixed-rate LED blinker. Each of `P_LED_NUM` channels runs in one of four runtime-selectable modes: off, on, blink (programmable half-period in ms), or breathe (PWM ramp). Sits between the board clock/PLL and the LED pins, driven from the PLL output clock with reset taken from the PLL lock.

## Interface
Parameters:
- `P_LED_NUM`, 2: number of LED channels, 1..32.
- `P_CLK_FREQ_HZ`, 10_000_000: `i_clk` frequency. Must be an integer multiple of 1000.
- `P_LED_ON`, 1: LED active level. 1 means the LED is lit when the pin is high; 0 means lit when low.
- `P_PWM_BITS`, 8: PWM resolution in bits, 4..12.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_cfg_load`, in, 1: single-cycle strobe that captures the two configuration inputs below.
- `i_mode`, in, 2*P_LED_NUM: per-channel mode; channel k uses bits [2k+1:2k]. Encoding: 00 off, 01 on, 10 blink, 11 breathe.
- `i_blink_ms`, in, 16: blink half-period in ms, shared by all channels.
- `o_ms_tick`, out, 1: one-cycle pulse once per millisecond.
- `o_led`, out, P_LED_NUM: LED pins, with polarity set by `P_LED_ON`.

## Operation
- **Shadow registers.**
  - `mode_q` and `blink_q` update only on a cycle where `i_cfg_load`=1.
  - Reset values: `mode_q`=all 00, `blink_q`=1000.
  - A captured `i_blink_ms` of 0 is stored as 1.
- **ms prescaler.**
  - Counts 0..`P_CLK_FREQ_HZ`/1000−1.
  - `o_ms_tick`=1 on the cycle the counter sits at its terminal value.
- **Blink timer.**
  - A 16-bit counter advances on each tick.
  - When a tick arrives with the counter at `blink_q`−1: the counter clears and `blink_ph` toggles.
  - `blink_ph` resets to 1 (lit).
- **Breathe generator.**
  - `duty` is `P_PWM_BITS` wide, with a direction flag `dir` (up/down).
  - On each tick, `duty` steps by 1 in the current direction.
  - At the top value 2^B−1, direction becomes down; at 0, it becomes up.
  - Full breathe cycle = 2·(2^B−1) ms; for B=8 this is 510 ms.
  - `pwm_cnt` is a free-running B-bit counter incremented every clock.
  - Lit condition is `pwm_cnt < duty`, so duty 0 means fully dark.
- **Channel select.** Per channel, `lit` is:
  - off → 0
  - on → 1
  - blink → `blink_ph`
  - breathe → PWM compare result
- **Output polarity.** `o_led[k]` = `lit[k]` when `P_LED_ON`=1, and ~`lit[k]` when `P_LED_ON`=0.
- **Effect of `i_cfg_load`.** On the load cycle, the next state is forced as follows:
  - prescaler = 0
  - blink counter = 0
  - `blink_ph` = 1
  - `duty` = 0
  - `dir` = up
  - `pwm_cnt` = 0
  - This gives all channels a phase-aligned restart.
- **Simultaneous load and tick.** Load wins; the tick's timer updates are discarded. `o_ms_tick` still pulses that cycle.

## Timing
- **Reset values.**
  - `o_led` = {P_LED_NUM{~P_LED_ON}} (all dark).
  - `o_ms_tick` = 0.
  - All counters = 0.
- **Output latency.** `o_led` and `o_ms_tick` are registered. Latency from internal state to pin is 1 clock.
- **Config latency.** Load on cycle N:
  - shadow registers valid at N+1;
  - `o_led` reflects the new mode at N+2.
- **First tick after load or reset release.** `o_ms_tick` first pulses `P_CLK_FREQ_HZ`/1000 cycles after the cycle in which the prescaler is 0.
- **Blink edges.** First toggle comes after `blink_q` ticks; later edges follow every `blink_q` ticks.
- **Reset mid-operation.** Reset asserts asynchronously: all state and outputs go to reset values immediately. Deassertion must be synchronous to `i_clk`; the reset synchroniser lives upstream.
- **Widths.**
  - Prescaler width is `$clog2(P_CLK_FREQ_HZ/1000)`.
  - Blink counter compare is done at 16 bits; no wrap beyond 65535.

## Structure
- Package `led_pkg` holds:
  - mode encodings LED_OFF/LED_ON/LED_BLINK/LED_BREATHE;
  - a function computing the prescaler terminal count from `P_CLK_FREQ_HZ`.
- Sub-module `led_tick_gen`:
  - contains the ms prescaler, with synchronous clear driven by `i_cfg_load`;
  - is reusable by other timing blocks.
- Blink timer, breathe generator and per-channel selection stay in the top module. They are shared timers with a generate loop over channels.

## Test plan
Bench parameters: `P_CLK_FREQ_HZ`=10_000 (10 clk/ms), `P_LED_NUM`=4, `P_PWM_BITS`=4.
- **Reset.** Hold `i_rst_n`=0 → `o_led`=4'b0000 with `P_LED_ON`=0 inverted to 4'b1111; `o_ms_tick`=0. Release → first tick after 10 clocks.
- **Static modes.** Load modes {on, off, on, off} → `o_led`=4'b0101 from load+2 and held for 1000 clocks.
- **Blink.** Load blink on all channels with `i_blink_ms`=3:
  - lit for 30 clocks, dark for 30 clocks, repeating;
  - `i_blink_ms`=0 instead gives a 10-clock half-period.
- **Breathe.** Count lit cycles per 16-clock window on channel 0:
  - over the first 15 ms, lit count = 0,1,2,…,14;
  - then it descends 15,14,…;
  - a full cycle is 30 ms.
- **Load/tick collision.** Assert `i_cfg_load` on a tick cycle → blink counter does not advance, `blink_ph`=1, next tick 10 clocks later.
- **Reset mid-blink.** Assert `i_rst_n`=0 mid-blink → outputs go dark asynchronously within the same cycle; modes revert to off.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED driver: mode encodings, ramp direction,
// prescaler terminal-count helper and the per-channel lit selector.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_ON      = 2'b01,
    LED_BLINK   = 2'b10,
    LED_BREATHE = 2'b11
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } led_dir_e;

  localparam logic [15:0] BLINK_MS_RST = 16'd1000;

  // Last prescaler count of a 1 ms period.
  function automatic int unsigned presc_tc(input int unsigned clk_hz);
    return clk_hz / 1000 - 1;
  endfunction

  function automatic logic led_sel(input logic [1:0] mode, input logic blink_ph,
                                   input logic pwm_lit);
    case (mode)
      LED_OFF:   return 1'b0;
      LED_ON:    return 1'b1;
      LED_BLINK: return blink_ph;
      default:   return pwm_lit;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Millisecond prescaler: combinational tick while the counter sits at its
// terminal value, synchronous clear for phase-aligned restarts.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned P_CLK_FREQ_HZ = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned DIV = P_CLK_FREQ_HZ / 1000;
  localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TC = W'(presc_tc(P_CLK_FREQ_HZ));

  logic [W-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clr || o_tick) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pwm_drive.sv
// Multi-channel LED driver: shared blink timer and breathe ramp, per-channel
// mode select, registered pins with configurable active level.
module led_pwm_drive
  import led_pkg::*;
#(
  parameter int unsigned P_LED_NUM     = 2,
  parameter int unsigned P_CLK_FREQ_HZ = 10_000_000,
  parameter bit          P_LED_ON      = 1'b1,
  parameter int unsigned P_PWM_BITS    = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cfg_load,
  input  logic [2*P_LED_NUM-1:0] i_mode,
  input  logic [15:0]            i_blink_ms,
  output logic                   o_ms_tick,
  output logic [P_LED_NUM-1:0]   o_led
);

  localparam logic [P_LED_NUM-1:0]  LED_DARK = {P_LED_NUM{~P_LED_ON}};
  localparam logic [P_PWM_BITS-1:0] DUTY_MAX = {P_PWM_BITS{1'b1}};

  logic                         ms_tick;
  logic [P_LED_NUM-1:0][1:0]    mode_q, mode_d;
  logic [15:0]                  blink_q, blink_d;
  logic [15:0]                  blk_cnt_q, blk_cnt_d;
  logic                         blink_ph_q, blink_ph_d;
  logic [P_PWM_BITS-1:0]        duty_q, duty_d;
  led_dir_e                     dir_q, dir_d;
  logic [P_PWM_BITS-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic                         pwm_lit;
  logic [P_LED_NUM-1:0]         lit;
  logic [P_LED_NUM-1:0]         led_q, led_d;
  logic                         tick_q;

  led_tick_gen #(
    .P_CLK_FREQ_HZ (P_CLK_FREQ_HZ)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_cfg_load),
    .o_tick  (ms_tick)
  );

  // Load takes priority over a coincident tick so every timer restarts in phase.
  always_comb begin
    mode_d     = mode_q;
    blink_d    = blink_q;
    blk_cnt_d  = blk_cnt_q;
    blink_ph_d = blink_ph_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    if (i_cfg_load) begin
      mode_d     = i_mode;
      blink_d    = (i_blink_ms == 16'd0) ? 16'd1 : i_blink_ms;
      blk_cnt_d  = '0;
      blink_ph_d = 1'b1;
      duty_d     = '0;
      dir_d      = DIR_UP;
      pwm_cnt_d  = '0;
    end else if (ms_tick) begin
      if (blk_cnt_q == blink_q - 16'd1) begin
        blk_cnt_d  = '0;
        blink_ph_d = ~blink_ph_q;
      end else begin
        blk_cnt_d  = blk_cnt_q + 16'd1;
      end
      if (dir_q == DIR_UP) begin
        duty_d = duty_q + 1'b1;
        if (duty_d == DUTY_MAX) dir_d = DIR_DOWN;
      end else begin
        duty_d = duty_q - 1'b1;
        if (duty_d == '0) dir_d = DIR_UP;
      end
    end
  end

  assign pwm_lit = (pwm_cnt_q < duty_q);

  for (genvar k = 0; k < P_LED_NUM; k++) begin : g_ch
    assign lit[k] = led_sel(mode_q[k], blink_ph_q, pwm_lit);
  end

  assign led_d = lit ^ LED_DARK;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q     <= '0;
      blink_q    <= BLINK_MS_RST;
      blk_cnt_q  <= '0;
      blink_ph_q <= 1'b1;
      duty_q     <= '0;
      dir_q      <= DIR_UP;
      pwm_cnt_q  <= '0;
      led_q      <= LED_DARK;
      tick_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      blink_q    <= blink_d;
      blk_cnt_q  <= blk_cnt_d;
      blink_ph_q <= blink_ph_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_q      <= led_d;
      tick_q     <= ms_tick;
    end
  end

  assign o_led     = led_q;
  assign o_ms_tick = tick_q;

endmodule

// File: tb/tb_led_pwm_drive.sv
// Directed bench for led_pwm_drive at 10 clk/ms, 4 channels, 4-bit PWM;
// a second instance with active-low pins checks output polarity.
module tb_led_pwm_drive;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] mode     = '0;
  logic [15:0] blink_ms = '0;
  logic       tick, tick_n;
  logic [3:0] led, led_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pwm_drive #(
    .P_LED_NUM(4), .P_CLK_FREQ_HZ(10_000), .P_LED_ON(1'b1), .P_PWM_BITS(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_load(cfg_load), .i_mode(mode),
    .i_blink_ms(blink_ms), .o_ms_tick(tick), .o_led(led)
  );

  led_pwm_drive #(
    .P_LED_NUM(4), .P_CLK_FREQ_HZ(10_000), .P_LED_ON(1'b0), .P_PWM_BITS(4)
  ) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_load(cfg_load), .i_mode(mode),
    .i_blink_ms(blink_ms), .o_ms_tick(tick_n), .o_led(led_n)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [15:0] ms);
    mode     = m;
    blink_ms = ms;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  // Triangle ramp 0..15..0 with one step per ms, period 30 ms.
  function automatic int breath_duty(input int ms);
    int m = ms % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  function automatic logic [3:0] breath_exp(input int s);
    return ((s % 16) < breath_duty(s / 10)) ? 4'hF : 4'h0;
  endfunction

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", led, 4'h0);
    chk("rst_led_n", led_n, 4'hF);
    chk("rst_tick", {3'b0, tick}, 4'h0);
    chk("rst_tick_n", {3'b0, tick_n}, 4'h0);

    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("rel_tick", {3'b0, tick}, {3'b0, (k % 10 == 0)});
    end
    chk("rel_led", led, 4'h0);

    // Static modes: ch0 on, ch1 off, ch2 on, ch3 off
    do_load(8'b00_01_00_01, 16'd5);
    chk("static_lat", led, 4'h0);
    for (int k = 1; k <= 1000; k++) begin
      step();
      chk("static_led", led, 4'b0101);
      chk("static_led_n", led_n, 4'b1010);
    end

    // Blink 3 ms half-period
    do_load(8'hAA, 16'd3);
    for (int k = 1; k <= 120; k++) begin
      step();
      chk("blink3", led, ((k - 1) % 60 < 30) ? 4'hF : 4'h0);
    end

    // Blink 0 ms stored as 1 ms
    do_load(8'hAA, 16'd0);
    for (int k = 1; k <= 60; k++) begin
      step();
      chk("blink0", led, ((k - 1) % 20 < 10) ? 4'hF : 4'h0);
    end

    // Load coinciding with a tick
    do_load(8'hAA, 16'd3);
    for (int k = 1; k <= 19; k++) begin
      step();
      chk("pre_coll_tick", {3'b0, tick}, {3'b0, (k == 10)});
    end
    do_load(8'hAA, 16'd3);
    chk("coll_tick", {3'b0, tick}, 4'h1);
    for (int k = 1; k <= 60; k++) begin
      step();
      chk("coll_led", led, ((k - 1) % 60 < 30) ? 4'hF : 4'h0);
      chk("coll_tick_per", {3'b0, tick}, {3'b0, (k % 10 == 0)});
    end

    // Breathe: two full 30 ms cycles
    do_load(8'hFF, 16'd0);
    for (int k = 1; k <= 600; k++) begin
      step();
      chk("breathe", led, breath_exp(k - 1));
      chk("breathe_n", led_n, ~breath_exp(k - 1));
    end

    // Reset mid-blink
    do_load(8'hAA, 16'd3);
    for (int k = 1; k <= 10; k++) step();
    chk("mid_pre_led", led, 4'hF);
    chk("mid_pre_tick", {3'b0, tick}, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_led", led, 4'h0);
    chk("mid_rst_led_n", led_n, 4'hF);
    chk("mid_rst_tick", {3'b0, tick}, 4'h0);
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("post_rst_off", led, 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
